// File: rtl/pixel_fetcher_pkg.sv
// Shared types and constants for the pixel fetcher: FSM states, AXI response code,
// default error word and watchdog counter width.
package pixel_fetcher_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_e;

   localparam logic [1:0]  RRESP_OKAY    = 2'b00;
   localparam logic [31:0] ERR_PIXEL_DEF = 32'hDEAD_BEEF;
   localparam int          WDOG_W        = 16;

endpackage

// File: rtl/if_axi_light.sv
// AXI-light bundle toward frame memory: full read channel, write-channel controls only.
interface if_axi_light;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        awvalid;
   logic        wvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, rready, awvalid, wvalid, bready,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awvalid, wvalid, bready,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/fetch_watchdog.sv
// Clear/enable cycle counter; expire is high on the enabled cycle whose count is
// TIMEOUT_CYCLES-1, which is a single cycle because the owner leaves the counted states.
module fetch_watchdog
   import pixel_fetcher_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic res,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

   logic [WDOG_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign expire = en && (cnt_q == LAST);

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pixel_fetcher.sv
// Turns edge-qualified pixel requests into single watchdog-guarded AXI-light reads.
// Macro PIXEL_CACHE_EN adds a single-entry last-address cache and the cache_flush port.
module pixel_fetcher
   import pixel_fetcher_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_PIXEL      = ERR_PIXEL_DEF
) (
   input  logic               clk,
   input  logic               res,
   if_axi_light.master        m_axi,
   input  logic [31:0]        addr_pixel,
   input  logic               request_pixel,
`ifdef PIXEL_CACHE_EN
   input  logic               cache_flush,
`endif
   output logic [31:0]        pixel,
   output logic               pixel_avail,
   output logic               busy,
   output logic [7:0]         err_count
);

   state_e      state_q, state_d;
   logic        req_prev_q;
   logic [31:0] araddr_q, araddr_d;
   logic [31:0] pixel_q, pixel_d;
   logic [7:0]  err_q, err_d;
   logic        drain_q, drain_d;
   logic        accept, wd_clr, wd_en, wd_expire, fail;
   logic [31:0] req_addr;

`ifdef PIXEL_CACHE_EN
   logic        cache_vld_q, cache_vld_d;
   logic [31:0] cache_addr_q, cache_addr_d;
   logic [31:0] cache_dat_q, cache_dat_d;
   logic        cache_hit;

   assign cache_hit = cache_vld_q && !cache_flush && (cache_addr_q == req_addr);
`endif

   assign accept   = (state_q == IDLE) && request_pixel && !req_prev_q;
   assign req_addr = (BASE_ADDR + addr_pixel) & 32'hFFFF_FFFC;
   assign wd_en    = (state_q == ADDR) || (state_q == DATA);

   fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk    (clk),
      .res    (res),
      .clr    (wd_clr),
      .en     (wd_en),
      .expire (wd_expire)
   );

   // A pending drain holds off arvalid so the stale beat cannot be taken as the new reply.
   assign m_axi.arvalid = (state_q == ADDR) && !drain_q;
   assign m_axi.araddr  = araddr_q;
   assign m_axi.rready  = (state_q == DATA) || drain_q;
   assign m_axi.awvalid = 1'b0;
   assign m_axi.wvalid  = 1'b0;
   assign m_axi.bready  = 1'b1;

   assign pixel       = pixel_q;
   assign pixel_avail = (state_q == RESP);
   assign busy        = (state_q != IDLE) || accept;
   assign err_count   = err_q;

   always_comb begin
      state_d  = state_q;
      araddr_d = araddr_q;
      pixel_d  = pixel_q;
      err_d    = err_q;
      drain_d  = drain_q;
      wd_clr   = 1'b0;
      fail     = 1'b0;
`ifdef PIXEL_CACHE_EN
      cache_vld_d  = cache_vld_q;
      cache_addr_d = cache_addr_q;
      cache_dat_d  = cache_dat_q;
`endif
      if (drain_q && m_axi.rvalid) begin
         drain_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               araddr_d = req_addr;
               wd_clr   = 1'b1;
`ifdef PIXEL_CACHE_EN
               if (cache_hit) begin
                  state_d = RESP;
                  pixel_d = cache_dat_q;
               end else begin
                  state_d = ADDR;
               end
`else
               state_d  = ADDR;
`endif
            end
         end
         ADDR: begin
            if (wd_expire) begin
               state_d = RESP;
               pixel_d = ERR_PIXEL;
               fail    = 1'b1;
               // Address taken on the abort cycle: a beat is still owed, so drain it.
               if (m_axi.arvalid && m_axi.arready) begin
                  drain_d = 1'b1;
               end
            end else if (m_axi.arvalid && m_axi.arready) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (m_axi.rvalid) begin
               state_d = RESP;
               if (m_axi.rresp == RRESP_OKAY) begin
                  pixel_d = m_axi.rdata;
`ifdef PIXEL_CACHE_EN
                  cache_vld_d  = 1'b1;
                  cache_addr_d = araddr_q;
                  cache_dat_d  = m_axi.rdata;
`endif
               end else begin
                  pixel_d = ERR_PIXEL;
                  fail    = 1'b1;
               end
            end else if (wd_expire) begin
               state_d = RESP;
               pixel_d = ERR_PIXEL;
               fail    = 1'b1;
               drain_d = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (fail) begin
         if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
         end
`ifdef PIXEL_CACHE_EN
         cache_vld_d = 1'b0;
`endif
      end
`ifdef PIXEL_CACHE_EN
      if (cache_flush) begin
         cache_vld_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q    <= IDLE;
         req_prev_q <= 1'b0;
         araddr_q   <= '0;
         pixel_q    <= '0;
         err_q      <= '0;
         drain_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_prev_q <= request_pixel;
         araddr_q   <= araddr_d;
         pixel_q    <= pixel_d;
         err_q      <= err_d;
         drain_q    <= drain_d;
      end
   end

`ifdef PIXEL_CACHE_EN
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         cache_vld_q  <= 1'b0;
         cache_addr_q <= '0;
         cache_dat_q  <= '0;
      end else begin
         cache_vld_q  <= cache_vld_d;
         cache_addr_q <= cache_addr_d;
         cache_dat_q  <= cache_dat_d;
      end
   end
`endif

endmodule

// File: tb/tb_pixel_fetcher.sv
// Scoreboarded bench for pixel_fetcher: scripted AXI-light slave, transaction-level model.
module tb_pixel_fetcher;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int          TO   = 16;
   localparam logic [31:0] ERRW = 32'hDEAD_BEEF;
   localparam int          NEVER = 1000;
`ifdef PIXEL_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic [31:0] addr_pixel = '0;
   logic        request_pixel = 1'b0;
   logic [31:0] pixel;
   logic        pixel_avail;
   logic        busy;
   logic [7:0]  err_count;
`ifdef PIXEL_CACHE_EN
   logic        cache_flush = 1'b0;
`endif

   if_axi_light axi ();

   pixel_fetcher #(
      .BASE_ADDR      (BASE),
      .TIMEOUT_CYCLES (TO),
      .ERR_PIXEL      (ERRW)
   ) dut (
      .clk           (clk),
      .res           (res),
      .m_axi         (axi),
      .addr_pixel    (addr_pixel),
      .request_pixel (request_pixel),
`ifdef PIXEL_CACHE_EN
      .cache_flush   (cache_flush),
`endif
      .pixel         (pixel),
      .pixel_avail   (pixel_avail),
      .busy          (busy),
      .err_count     (err_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [31:0] pix;
      logic [7:0]  errc;
      int          lat;
      int          req_cyc;
   } exp_t;

   exp_t sb[$];

   // Per-transaction slave behaviour, set by the driver before each request.
   int          cfg_ar_wait = 0;
   int          cfg_r_wait  = 0;
   logic [1:0]  cfg_rresp   = 2'b00;
   logic [31:0] cfg_rdata   = '0;
   logic [31:0] exp_araddr  = '0;
   int          n_ar = 0;
   int          exp_n_ar = 0;

   // Slave: acts on falling edges; the DUT samples the result on the next rising edge.
   int          ar_cnt = 0;
   int          r_cnt = 0;
   int          r_wait = 0;
   bit          r_pending = 1'b0;
   bit          r_hs = 1'b0;
   logic [1:0]  r_resp = 2'b00;
   logic [31:0] r_data = '0;

   initial begin
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      axi.rdata   = '0;
      axi.rresp   = 2'b00;
      forever begin
         @(negedge clk);
         axi.arready = 1'b0;
         if (r_hs) begin
            axi.rvalid = 1'b0;
            r_pending  = 1'b0;
            r_hs       = 1'b0;
         end else if (r_pending && !axi.rvalid) begin
            if (r_cnt >= r_wait) begin
               axi.rvalid = 1'b1;
               axi.rdata  = r_data;
               axi.rresp  = r_resp;
            end else begin
               r_cnt++;
            end
         end
         if (axi.rvalid && axi.rready) r_hs = 1'b1;
         if (axi.arvalid) begin
            if (ar_cnt == cfg_ar_wait) begin
               axi.arready = 1'b1;
               ar_cnt      = 0;
               n_ar++;
               check("araddr", axi.araddr, exp_araddr);
               r_pending = 1'b1;
               r_cnt     = 0;
               r_wait    = cfg_r_wait;
               r_resp    = cfg_rresp;
               r_data    = cfg_rdata;
            end else begin
               ar_cnt++;
            end
         end else begin
            ar_cnt = 0;
         end
      end
   end

   // Monitor: every pixel_avail pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!res && pixel_avail) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_avail: got pixel_avail=1 pixel=%h, expected no pulse (cycle %0d)", pixel, cyc);
         end else begin
            e = sb.pop_front();
            check("pixel", pixel, e.pix);
            check("err_count", {24'd0, err_count}, {24'd0, e.errc});
            check("latency", cyc - e.req_cyc, e.lat);
            check("busy_at_avail", {31'd0, busy}, 32'd1);
         end
      end
   end

   // Reference model: whole-transaction outcome from slave timing and response.
   logic [7:0]  m_err = '0;
   bit          c_vld = 1'b0;
   logic [31:0] c_addr = '0;
   logic [31:0] c_dat = '0;

   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while ((busy || r_pending || axi.rvalid || sb.size() != 0) && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (k >= 400) begin
         n_cmp++;
         n_bad++;
         $display("FAIL idle_timeout: busy=%0b queued=%0d, expected idle within 400 cycles", busy, sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic issue(input logic [31:0] addr, input int arw, input int rw,
                        input logic [1:0] rresp, input logic [31:0] rdata,
                        input int hold, input bit flush);
      exp_t        e;
      logic [31:0] a;
      int          total;
      bit          hit, bad;
      wait_idle();
      a = (BASE + addr) & 32'hFFFF_FFFC;
      if (flush) c_vld = 1'b0;
      hit   = CACHE && c_vld && (c_addr == a);
      total = arw + rw + 2;
      if (hit) begin
         e.pix = c_dat;
         e.lat = 1;
      end else begin
         if (arw < TO - 1) exp_n_ar++;
         e.lat = ((total > TO) ? TO : total) + 1;
         bad   = (total > TO) || (rresp != 2'b00);
         e.pix = bad ? ERRW : rdata;
         if (bad) begin
            if (m_err != 8'hFF) m_err++;
            c_vld = 1'b0;
         end else begin
            c_vld  = 1'b1;
            c_addr = a;
            c_dat  = rdata;
         end
      end
      e.errc      = m_err;
      e.req_cyc   = cyc;
      cfg_ar_wait = arw;
      cfg_r_wait  = rw;
      cfg_rresp   = rresp;
      cfg_rdata   = rdata;
      exp_araddr  = a;
      sb.push_back(e);
      addr_pixel    = addr;
      request_pixel = 1'b1;
`ifdef PIXEL_CACHE_EN
      cache_flush   = flush;
`endif
      #1;
      check("busy_on_accept", {31'd0, busy}, 32'd1);
      @(negedge clk);
`ifdef PIXEL_CACHE_EN
      cache_flush = 1'b0;
`endif
      repeat (hold - 1) @(negedge clk);
      request_pixel = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $fatal(1, "global timeout");
   end

   initial begin
      int arw, rw, hold;
      logic [1:0] rr;

      repeat (3) @(negedge clk);
      check("rst_pixel", pixel, 32'd0);
      check("rst_pixel_avail", {31'd0, pixel_avail}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err_count", {24'd0, err_count}, 32'd0);
      check("rst_arvalid", {31'd0, axi.arvalid}, 32'd0);
      check("rst_araddr", axi.araddr, 32'd0);
      check("rst_rready", {31'd0, axi.rready}, 32'd0);
      check("tie_write", {29'd0, axi.awvalid, axi.wvalid, axi.bready}, 32'd1);
      res = 1'b0;

      issue(32'h10, 0, 0, 2'b00, 32'h00AB_CDEF, 1, 1'b0);
      issue(32'h24, 0, 0, 2'b00, 32'h1234_5678, 20, 1'b0);
      issue(32'h33, 0, 1, 2'b10, 32'h5555_AAAA, 1, 1'b0);
      issue(32'h40, 0, 14, 2'b00, 32'hCAFE_0001, 1, 1'b0);
      issue(32'h44, 0, 19, 2'b00, 32'hBAD0_BAD0, 1, 1'b0);
      issue(32'h48, 0, 0, 2'b00, 32'h0F0F_0F0F, 1, 1'b0);
      issue(32'h48, 0, 0, 2'b00, 32'h1111_2222, 1, 1'b0);
      issue(32'h48, 0, 0, 2'b00, 32'h3333_4444, 1, 1'b1);
      issue(32'h50, 2, 3, 2'b00, 32'h7777_8888, 3, 1'b0);

      for (int i = 0; i < 60; i++) begin
         arw  = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 3);
         rw   = $urandom_range(0, 20);
         rr   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         hold = $urandom_range(1, 4);
         issue(32'($urandom_range(0, 15)), arw, rw, rr, $urandom, hold,
               $urandom_range(0, 3) == 0);
      end

      for (int i = 0; i < 300; i++) begin
         issue(32'h60, NEVER, 0, 2'b00, 32'd0, 1, 1'b0);
      end
      wait_idle();
      check("err_saturated", {24'd0, err_count}, 32'h0000_00FF);
      check("axi_read_count", n_ar, exp_n_ar);
      check("scoreboard_empty", sb.size(), 0);

      // Asynchronous reset while a read is stuck in ADDR.
      cfg_ar_wait   = NEVER;
      addr_pixel    = 32'h70;
      request_pixel = 1'b1;
      repeat (3) @(negedge clk);
      request_pixel = 1'b0;
      check("mid_arvalid_before_reset", {31'd0, axi.arvalid}, 32'd1);
      #2 res = 1'b1;
      #1;
      check("mid_rst_arvalid", {31'd0, axi.arvalid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
      check("mid_rst_pixel", pixel, 32'd0);
      check("mid_rst_araddr", axi.araddr, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pixel_fetcher.md
Name: pixel_fetcher

Overview:
- Services the pixel-request handshake from the memory controller's control block (addr_pixel/request_pixel in, pixel/pixel_avail out).
- Turns each request into a single AXI-light read on a master port toward frame memory, then returns the read word.
- Guards every read with a watchdog timeout and error accounting, so a stalled slave cannot hang the control block.

Parameters:
- BASE_ADDR, 32'h0000_0000, added to addr_pixel to form the AXI read address.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in ADDR+DATA before abort; legal range 2..65535.
- ERR_PIXEL, 32'hDEAD_BEEF, value returned on timeout or non-OKAY response.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  reset; asynchronous, active-high.
- m_axi  if_axi_light.master  -  read channel only (araddr/arvalid/arready, rdata/rresp/rvalid/rready); write channel tied idle (awvalid=0, wvalid=0, bready=1).
- addr_pixel  in  32  word address of the requested pixel.
- request_pixel  in  1  request; rising-edge qualified.
- pixel  out  32  returned pixel word; held until the next response.
- pixel_avail  out  1  one-cycle pulse, pixel valid.
- busy  out  1  high from request acceptance until the pixel_avail cycle, inclusive.
- err_count  out  8  saturating count of errored fetches.

Behaviour:
- Reset values: pixel=0, pixel_avail=0, busy=0, err_count=0, arvalid=0, araddr=0, rready=0, state=IDLE, request edge register=0.
- Request edge detect:
  - A request is accepted in IDLE when request_pixel=1 and it was 0 in the previous cycle.
  - A held-high request does not retrigger; edges outside IDLE are ignored, not queued.
- On acceptance: araddr <= BASE_ADDR + addr_pixel (mod 2^32), with araddr[1:0] forced to 0.
- States:
  - IDLE: wait for an accepted request -> ADDR.
  - ADDR: arvalid=1 and address stable; on arvalid&arready -> DATA with arvalid<=0.
  - DATA: rready=1; on rvalid, register rdata and rresp -> RESP.
  - RESP: pixel_avail=1 for exactly one cycle -> IDLE.
- Response value:
  - rresp==OKAY: pixel=rdata.
  - Otherwise: pixel=ERR_PIXEL and err_count+1.
- Latency with a zero-wait slave: request edge seen at cycle T, arvalid at T+1, rvalid at T+2, pixel_avail at T+3.
- Watchdog:
  - Counter clears on acceptance and counts every cycle in ADDR and DATA.
  - Reaching TIMEOUT_CYCLES-1 forces RESP with pixel=ERR_PIXEL and err_count+1.
  - A timeout in ADDR drops arvalid (accepted AXI-light deviation).
  - After a timeout in DATA, a drain flag is set. While it is set, rready=1 in IDLE; the next rvalid is discarded and the flag clears.
  - A new request is accepted while draining. In that case ADDR waits for the drain to clear before asserting arvalid.
- err_count saturates at 8'hFF.
- Simultaneous rvalid and timeout in the same cycle: rvalid wins and no error is counted.
- Asynchronous reset mid-transaction: immediate return to IDLE with all outputs at reset values. An outstanding slave beat is the slave's responsibility.

Optional Feature:
- Macro PIXEL_CACHE_EN enables a single-entry last-address cache.
- With the macro defined:
  - The block stores {valid, araddr, data} for the last OKAY fetch.
  - An accepted request whose computed address matches a valid entry skips ADDR/DATA; pixel_avail rises at T+1 and no AXI traffic is issued.
  - Timeouts, errored responses and reset invalidate the entry.
  - An extra input port cache_flush (in, 1) invalidates the entry the same cycle. When cache_flush coincides with a hit, the flush wins and the request fetches.
- Without the macro: no cache storage and no cache_flush port; every request issues an AXI read.

Decomposition:
- Package pixel_fetcher_pkg holds:
  - the state enum (IDLE, ADDR, DATA, RESP);
  - localparam RRESP_OKAY=2'b00;
  - the default ERR_PIXEL constant;
  - the watchdog counter width (16).
- One sub-module, fetch_watchdog: clear/enable/expire counter parameterised by TIMEOUT_CYCLES, with a one-cycle expire pulse.

Test Plan:
- Zero-wait slave, addr_pixel=32'h10, BASE_ADDR=32'h1000, rdata=32'h00AB_CDEF -> araddr=32'h1010; pixel_avail at T+3 with pixel=32'h00AB_CDEF; busy high T..T+3.
- request_pixel held high for 20 cycles -> exactly one AXI read and one pixel_avail pulse.
- Slave never asserts arready, TIMEOUT_CYCLES=16 -> arvalid drops; pixel_avail with 32'hDEAD_BEEF; err_count=1. Repeat 300 times -> err_count=8'hFF.
- rvalid arrives 5 cycles after a DATA timeout (TIMEOUT_CYCLES=16) -> beat drained with no pixel_avail; next request returns fresh data.
- rresp=2'b10 -> pixel=ERR_PIXEL and err_count increments. Separately, rvalid on the expiry cycle -> real data and no count.
- PIXEL_CACHE_EN defined, same address twice -> second request pixel_avail at T+1 with no arvalid. Repeat with cache_flush pulsed coincident with the second request -> it issues an AXI read.
